// File: rtl/slave_split_mem.sv
// slave_split_mem: bus memory responder with optional split reads.
// A read parks the transaction here during the access latency, then the slave
// re-requests the bus from the arbiter to return the data. Writes never split.
module slave_split_mem #(
  parameter int unsigned ADDR_W   = 12,
  parameter int unsigned DATA_W   = 8,
  parameter int unsigned LATENCY  = 4,
  parameter int unsigned SPLIT_EN = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [15:0]       addr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              mode,
  input  logic              valid,
  input  logic              sl,
  output logic [DATA_W-1:0] rdata,
  output logic              ready,
  output logic              split,
  output logic              arbiter_req,
  input  logic              arbiter_grant
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 2 ** ADDR_W;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WAIT  = 3'd1,
    SPLIT = 3'd2,
    REQ   = 3'd3,
    RESP  = 3'd4
  } state_t;

  state_t              state;
  logic [CNT_W-1:0]    cnt;
  logic [ADDR_W-1:0]   a_q;
  logic [DATA_W-1:0]   wdata_q;
  logic                mode_q;
  logic [DATA_W-1:0]   mem [DEPTH];

  logic                mem_we_c;
  logic                unused_addr_hi_c;

  // Upper address bits alias onto the same memory words.
  assign unused_addr_hi_c = ^addr[15:ADDR_W];

  // Write strobe: the WAIT counter expires on a latched write.
  assign mem_we_c = (state == WAIT) && (cnt == '0) && mode_q;

  // Memory array; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we_c) begin
      mem[a_q] <= wdata_q;
    end
  end

  // Transaction FSM with registered bus outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      a_q         <= '0;
      wdata_q     <= '0;
      mode_q      <= 1'b0;
      rdata       <= '0;
      ready       <= 1'b0;
      split       <= 1'b0;
      arbiter_req <= 1'b0;
    end else begin
      ready <= 1'b0;
      split <= 1'b0;
      case (state)
        IDLE: begin
          if (valid && sl) begin
            a_q     <= addr[ADDR_W-1:0];
            wdata_q <= wdata;
            mode_q  <= mode;
            cnt     <= CNT_W'(LATENCY - 1);
            if (!mode && (SPLIT_EN != 0)) begin
              state <= SPLIT;
              split <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
        end
        WAIT: begin
          if (cnt == '0) begin
            if (!mode_q) begin
              rdata <= mem[a_q];
            end
            ready <= 1'b1;
            state <= RESP;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        SPLIT: begin
          if (cnt == '0) begin
            rdata       <= mem[a_q];
            arbiter_req <= 1'b1;
            state       <= REQ;
          end else begin
            cnt <= cnt - CNT_W'(1);
          end
        end
        REQ: begin
          if (arbiter_grant) begin
            arbiter_req <= 1'b0;
            ready       <= 1'b1;
            state       <= RESP;
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state       <= IDLE;
          arbiter_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slave_split_mem.sv
// Bench for slave_split_mem: three instances (non-split L=4, split L=4,
// non-split L=1) share the bus inputs and are addressed by their own select.
module tb_slave_split_mem;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr;
  logic [7:0]  wdata;
  logic        mode, valid, arbiter_grant;
  logic [2:0]  sl_v;
  logic [2:0]  ready_v, split_v, req_v;
  logic [7:0]  rdata_v [3];

  always #5 clk = ~clk;

  slave_split_mem #(.ADDR_W(12), .DATA_W(8), .LATENCY(4), .SPLIT_EN(0)) dut_ns (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mode(mode), .valid(valid),
    .sl(sl_v[0]), .rdata(rdata_v[0]), .ready(ready_v[0]), .split(split_v[0]),
    .arbiter_req(req_v[0]), .arbiter_grant(arbiter_grant));

  slave_split_mem #(.ADDR_W(12), .DATA_W(8), .LATENCY(4), .SPLIT_EN(1)) dut_sp (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mode(mode), .valid(valid),
    .sl(sl_v[1]), .rdata(rdata_v[1]), .ready(ready_v[1]), .split(split_v[1]),
    .arbiter_req(req_v[1]), .arbiter_grant(arbiter_grant));

  slave_split_mem #(.ADDR_W(12), .DATA_W(8), .LATENCY(1), .SPLIT_EN(0)) dut_l1 (
    .clk(clk), .rst_n(rst_n), .addr(addr), .wdata(wdata), .mode(mode), .valid(valid),
    .sl(sl_v[2]), .rdata(rdata_v[2]), .ready(ready_v[2]), .split(split_v[2]),
    .arbiter_req(req_v[2]), .arbiter_grant(arbiter_grant));

  int checks = 0;
  int errors = 0;

  // Reference model: per-instance byte memory plus last returned read data.
  logic [7:0] mem_m   [3][4096];
  bit         wr_m    [3][4096];
  logic [7:0] last_rd [3];
  bit         last_ok [3];

  typedef struct {
    int          d;
    bit          wr;
    logic [15:0] ad;
    logic [7:0]  wd;
    int          gdly;
    int          er;
    int          es;
    int          eq;
    bit          chk;
    logic [7:0]  erd;
  } vec_t;

  vec_t vt [10];

  function automatic int lat_of(input int d);
    return (d == 2) ? 1 : 4;
  endfunction

  function automatic bit split_of(input int d);
    return d == 1;
  endfunction

  task automatic check(input string nm, input int got, input int exp);
    checks++;
    if (got != exp) begin
      errors++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, got, got, exp, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    for (int i = 0; i < 3; i++) begin
      last_rd[i] = 8'h00;
      last_ok[i] = 1'b1;
    end
  endtask

  // One full transaction on instance d; observes ready/split/req timing.
  task automatic do_txn(input string nm, input int d, input bit wr, input logic [15:0] ad,
                        input logic [7:0] wd, input int gdly, input bit noise,
                        input int exp_ready, input int exp_split, input int exp_req,
                        input bit chk_rd, input logic [7:0] exp_rd);
    int t_ready, t_split, n_split, t_req, n_ovl;
    logic [7:0] got_rd;
    logic [11:0] a;
    t_ready = -1; t_split = -1; n_split = 0; t_req = -1; n_ovl = 0; got_rd = 8'h00;
    a = ad[11:0];
    tick();
    addr = ad; wdata = wd; mode = wr; valid = 1'b1;
    sl_v = 3'b000; sl_v[d] = 1'b1;
    for (int k = 1; k <= 40 && t_ready < 0; k++) begin
      tick();
      if (k == 1) begin
        valid = 1'b0; sl_v = 3'b000;
        addr = 16'($urandom); wdata = 8'($urandom); mode = 1'($urandom);
      end
      if (ready_v[d]) begin t_ready = k; got_rd = rdata_v[d]; end
      if (split_v[d]) begin n_split++; if (t_split < 0) t_split = k; end
      if (req_v[d] && t_req < 0) t_req = k;
      if (int'(ready_v[d]) + int'(split_v[d]) + int'(req_v[d]) > 1) n_ovl++;
      if (t_req >= 0) arbiter_grant = (k == t_req + gdly);
      else arbiter_grant = noise ? 1'($urandom) : 1'b0;
    end
    arbiter_grant = 1'b0;
    check({nm, "_ready_cycle"}, t_ready, exp_ready);
    check({nm, "_split_cycle"}, t_split, exp_split);
    check({nm, "_split_count"}, n_split, (exp_split >= 0) ? 1 : 0);
    check({nm, "_req_cycle"}, t_req, exp_req);
    check({nm, "_overlap"}, n_ovl, 0);
    if (!wr && chk_rd) check({nm, "_rdata"}, int'(got_rd), int'(exp_rd));
    if (wr && last_ok[d]) check({nm, "_rdata_hold"}, int'(got_rd), int'(last_rd[d]));
    tick();
    check({nm, "_ready_pulse"}, int'(ready_v[d]), 0);
    check({nm, "_req_clear"}, int'(req_v[d]), 0);
    if (wr) begin
      mem_m[d][a] = wd; wr_m[d][a] = 1'b1;
    end else begin
      last_rd[d] = exp_rd; last_ok[d] = chk_rd;
    end
  endtask

  task automatic check_idle_outputs(input string nm);
    for (int d = 0; d < 3; d++) begin
      check($sformatf("%s_ready%0d", nm, d), int'(ready_v[d]), 0);
      check($sformatf("%s_split%0d", nm, d), int'(split_v[d]), 0);
      check($sformatf("%s_req%0d", nm, d), int'(req_v[d]), 0);
      check($sformatf("%s_rdata%0d", nm, d), int'(rdata_v[d]), 0);
    end
  endtask

  initial begin
    int act, nrdy;
    rst_n = 1'b0; addr = '0; wdata = '0; mode = 1'b0; valid = 1'b0;
    sl_v = 3'b000; arbiter_grant = 1'b0;
    for (int d = 0; d < 3; d++)
      for (int i = 0; i < 4096; i++) begin mem_m[d][i] = 8'h00; wr_m[d][i] = 1'b0; end
    model_reset();

    // Reset state
    repeat (2) tick();
    check_idle_outputs("reset");
    @(negedge clk) rst_n = 1'b1;

    // Directed vectors: {dut, wr, addr, wdata, grant delay, ready, split, req, chk, rdata}
    vt[0] = '{0, 1'b1, 16'h0010, 8'hA5, 0, 5, -1, -1, 1'b0, 8'h00};
    vt[1] = '{0, 1'b0, 16'h0010, 8'h00, 0, 5, -1, -1, 1'b1, 8'hA5};
    vt[2] = '{1, 1'b1, 16'h0010, 8'hA5, 0, 5, -1, -1, 1'b0, 8'h00};
    vt[3] = '{1, 1'b0, 16'h0010, 8'h00, 4, 10, 1, 5, 1'b1, 8'hA5};
    vt[4] = '{1, 1'b0, 16'h0010, 8'h00, 0, 6, 1, 5, 1'b1, 8'hA5};
    vt[5] = '{0, 1'b1, 16'h1005, 8'h5A, 0, 5, -1, -1, 1'b0, 8'h00};
    vt[6] = '{0, 1'b0, 16'h0005, 8'h00, 0, 5, -1, -1, 1'b1, 8'h5A};
    vt[7] = '{2, 1'b1, 16'h0040, 8'h11, 0, 2, -1, -1, 1'b0, 8'h00};
    vt[8] = '{2, 1'b0, 16'h0040, 8'h00, 0, 2, -1, -1, 1'b1, 8'h11};
    vt[9] = '{0, 1'b1, 16'h0020, 8'hC3, 0, 5, -1, -1, 1'b0, 8'h00};
    for (int i = 0; i < 10; i++)
      do_txn($sformatf("vec%0d", i), vt[i].d, vt[i].wr, vt[i].ad, vt[i].wd, vt[i].gdly, 1'b0,
             vt[i].er, vt[i].es, vt[i].eq, vt[i].chk, vt[i].erd);

    // Busy: a second request held during WAIT must be ignored
    tick();
    addr = 16'h0050; wdata = 8'h99; mode = 1'b1; valid = 1'b1; sl_v = 3'b001;
    nrdy = 0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      if (k == 1) begin addr = 16'h0020; wdata = 8'h3C; end
      if (k == 4) begin valid = 1'b0; sl_v = 3'b000; end
      if (ready_v[0]) nrdy++;
      if (k == 5) check("busy_ready_c5", int'(ready_v[0]), 1);
    end
    check("busy_ready_count", nrdy, 1);
    mem_m[0][12'h050] = 8'h99; wr_m[0][12'h050] = 1'b1;
    do_txn("busy_rd20", 0, 1'b0, 16'h0020, 8'h00, 0, 1'b0, 5, -1, -1, 1'b1, 8'hC3);
    do_txn("busy_rd50", 0, 1'b0, 16'h0050, 8'h00, 0, 1'b0, 5, -1, -1, 1'b1, 8'h99);

    // Reset during a write drops it and clears outputs asynchronously
    do_txn("rst_pre_wr", 0, 1'b1, 16'h0030, 8'h12, 0, 1'b0, 5, -1, -1, 1'b0, 8'h00);
    do_txn("rst_pre_rd", 0, 1'b0, 16'h0010, 8'h00, 0, 1'b0, 5, -1, -1, 1'b1, 8'hA5);
    tick();
    addr = 16'h0030; wdata = 8'h77; mode = 1'b1; valid = 1'b1; sl_v = 3'b001;
    tick();
    valid = 1'b0; sl_v = 3'b000;
    tick();
    rst_n = 1'b0;
    #1;
    check_idle_outputs("rst_async");
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    do_txn("rst_rd30", 0, 1'b0, 16'h0030, 8'h00, 0, 1'b0, 5, -1, -1, 1'b1, 8'h12);

    // Reset while requesting the bus
    tick();
    addr = 16'h0010; mode = 1'b0; valid = 1'b1; sl_v = 3'b010;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin valid = 1'b0; sl_v = 3'b000; end
    end
    check("req_before_rst", int'(req_v[1]), 1);
    rst_n = 1'b0;
    #1;
    check("req_async_clear", int'(req_v[1]), 0);
    @(negedge clk) rst_n = 1'b1;
    model_reset();
    do_txn("req_recover", 1, 1'b0, 16'h0010, 8'h00, 2, 1'b0, 8, 1, 5, 1'b1, 8'hA5);

    // Unselected requests never get a response
    tick();
    addr = 16'h0005; mode = 1'b0; valid = 1'b1; sl_v = 3'b000; arbiter_grant = 1'b1;
    act = 0;
    for (int k = 0; k < 20; k++) begin
      tick();
      act += int'(|ready_v) + int'(|split_v) + int'(|req_v);
    end
    valid = 1'b0; arbiter_grant = 1'b0;
    check("nosel_activity", act, 0);

    // LATENCY=1 back-to-back: ready at cycle 2, re-accept at 3, ready at 5
    tick();
    addr = 16'h0040; mode = 1'b0; valid = 1'b1; sl_v = 3'b100;
    tick();
    valid = 1'b0; sl_v = 3'b000;
    check("b2b_c1_ready", int'(ready_v[2]), 0);
    tick();
    check("b2b_c2_ready", int'(ready_v[2]), 1);
    check("b2b_c2_rdata", int'(rdata_v[2]), 8'h11);
    tick();
    check("b2b_c3_ready", int'(ready_v[2]), 0);
    addr = 16'h0041; wdata = 8'h22; mode = 1'b1; valid = 1'b1; sl_v = 3'b100;
    tick();
    valid = 1'b0; sl_v = 3'b000;
    check("b2b_c4_ready", int'(ready_v[2]), 0);
    tick();
    check("b2b_c5_ready", int'(ready_v[2]), 1);
    mem_m[2][12'h041] = 8'h22; wr_m[2][12'h041] = 1'b1;
    last_rd[2] = 8'h11; last_ok[2] = 1'b1;
    do_txn("b2b_rd41", 2, 1'b0, 16'h0041, 8'h00, 0, 1'b0, 2, -1, -1, 1'b1, 8'h22);

    // Randomized transactions against the model
    for (int i = 0; i < 60; i++) begin
      int d, gd, er, es, eq;
      bit wr, sp;
      logic [15:0] ad;
      logic [11:0] a;
      d  = int'($urandom_range(0, 2));
      wr = 1'($urandom);
      ad = {4'($urandom), 8'h00, 4'($urandom_range(0, 7))};
      a  = ad[11:0];
      gd = int'($urandom_range(0, 5));
      sp = split_of(d) && !wr;
      er = sp ? lat_of(d) + 1 + gd + 1 : lat_of(d) + 1;
      es = sp ? 1 : -1;
      eq = sp ? lat_of(d) + 1 : -1;
      do_txn($sformatf("rnd%0d", i), d, wr, ad, 8'($urandom), gd, 1'b1, er, es, eq,
             wr_m[d][a], mem_m[d][a]);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Global watchdog
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule
